// File: rtl/mem_line_fill.sv
// Critical-word-first cache line fill engine; first read MISS_LATENCY-1 cycles after accept, data one cycle later.
// Backpressure: req_ready only in IDLE, requests outside IDLE are dropped, no queuing.
module mem_line_fill #(
    parameter int          LINE_WORDS   = 4,
    parameter int          MISS_LATENCY = 16,
    parameter logic [31:0] START_ADRESS = 32'h00400000,
    parameter int          MP_WIDHT     = 8192
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    output logic                          mem_ce_n,
    output logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_rdata,
    output logic                          fill_valid,
    output logic [31:0]                   fill_data,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic                          fill_last,
    output logic                          hold_o,
    output logic                          err
);
    localparam int IW  = $clog2(LINE_WORDS);
    localparam int OFS = IW + 2;
    localparam int CW  = $clog2(MISS_LATENCY + 1);
    localparam int NW  = IW + 1;

    localparam logic [32:0]   ADDR_LO  = {1'b0, START_ADRESS};
    localparam logic [32:0]   ADDR_HI  = ADDR_LO + 33'(4 * MP_WIDHT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MISS_LATENCY - 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   base_q, base_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NW-1:0] nrd_q, nrd_d;
    logic          fv_q, fv_d;
    logic [IW-1:0] fidx_q, fidx_d;
    logic          flast_q, flast_d;

    logic in_range;
    logic rd_active;
    logic rd_last;

    assign in_range = ({1'b0, req_addr} >= ADDR_LO) && ({1'b0, req_addr} < ADDR_HI);

    // The first read issues from WAIT in its final cycle so MISS_LATENCY=2 still needs a WAIT state.
    assign rd_active = ((state_q == S_WAIT) && (cnt_q == '0)) ||
                       ((state_q == S_BURST) && (nrd_q != NW'(LINE_WORDS)));
    assign rd_last   = (nrd_q == NW'(LINE_WORDS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        idx_d   = idx_q;
        nrd_d   = nrd_q;
        fv_d    = rd_active;
        fidx_d  = rd_active ? idx_q : '0;
        flast_d = rd_active && rd_last;

        if (rd_active) begin
            idx_d = idx_q + IW'(1);
            nrd_d = nrd_q + NW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    base_d  = {req_addr[31:OFS], {OFS{1'b0}}};
                    idx_d   = req_addr[OFS-1:2];
                    nrd_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = in_range ? S_WAIT : S_ERR;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_BURST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_BURST: begin
                if (flast_q) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            nrd_q   <= '0;
            fv_q    <= 1'b0;
            fidx_q  <= '0;
            flast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            nrd_q   <= nrd_d;
            fv_q    <= fv_d;
            fidx_q  <= fidx_d;
            flast_q <= flast_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && reset_n;
    assign mem_ce_n   = ~rd_active;
    assign mem_addr   = rd_active ? (base_q | {{(30 - IW){1'b0}}, idx_q, 2'b00}) : 32'd0;
    assign fill_valid = fv_q;
    assign fill_data  = fv_q ? mem_rdata : 32'd0;
    assign fill_idx   = fidx_q;
    assign fill_last  = flast_q;
    assign hold_o     = (state_q != S_IDLE);
    assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_mem_line_fill.sv
// Bench for mem_line_fill: default instance plus a MISS_LATENCY=2 / LINE_WORDS=8 instance.
module tb_mem_line_fill;
    localparam logic [31:0] START = 32'h00400000;
    localparam int          MPW   = 8192;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] req_addr;
    logic        rv1, rv2;

    logic        rdy1, ce1, fv1, fl1, h1, e1;
    logic [31:0] ma1, rd1, fd1;
    logic [1:0]  fi1;
    logic        rdy2, ce2, fv2, fl2, h2, e2;
    logic [31:0] ma2, rd2, fd2;
    logic [2:0]  fi2;

    int cur;
    logic [31:0] m_rdy, m_ce, m_ma, m_fv, m_fd, m_fi, m_fl, m_h, m_e;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_line_fill u_dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv1), .req_ready(rdy1), .req_addr(req_addr),
        .mem_ce_n(ce1), .mem_addr(ma1), .mem_rdata(rd1), .fill_valid(fv1), .fill_data(fd1),
        .fill_idx(fi1), .fill_last(fl1), .hold_o(h1), .err(e1)
    );

    mem_line_fill #(.LINE_WORDS(8), .MISS_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv2), .req_ready(rdy2), .req_addr(req_addr),
        .mem_ce_n(ce2), .mem_addr(ma2), .mem_rdata(rd2), .fill_valid(fv2), .fill_data(fd2),
        .fill_idx(fi2), .fill_last(fl2), .hold_o(h2), .err(e2)
    );

    function automatic logic [31:0] mem_fn(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A0F0F;
    endfunction

    // Backing stores: registered read, data one cycle after mem_ce_n low.
    always_ff @(posedge clk) begin
        rd1 <= !ce1 ? mem_fn(ma1) : 32'hDEADBEEF;
        rd2 <= !ce2 ? mem_fn(ma2) : 32'hDEADBEEF;
    end

    always_comb begin
        m_rdy = 32'(cur == 1 ? rdy2 : rdy1);
        m_ce  = 32'(cur == 1 ? ce2  : ce1);
        m_ma  = cur == 1 ? ma2 : ma1;
        m_fv  = 32'(cur == 1 ? fv2  : fv1);
        m_fd  = cur == 1 ? fd2 : fd1;
        m_fi  = cur == 1 ? 32'(fi2) : 32'(fi1);
        m_fl  = 32'(cur == 1 ? fl2  : fl1);
        m_h   = 32'(cur == 1 ? h2   : h1);
        m_e   = 32'(cur == 1 ? e2   : e1);
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request at the current negedge, then checks every cycle up to and
    // including the first cycle where the engine is ready again.
    task automatic run_txn(int sel, logic [31:0] addr, bit keep);
        int          ml, lw, crit, n, r, f;
        logic [31:0] base;
        bit          ok;
        ml   = (sel == 1) ? 2 : 16;
        lw   = (sel == 1) ? 8 : 4;
        base = addr & ~(32'(lw * 4) - 32'd1);
        crit = int'((addr >> 2) % 32'(lw));
        ok   = (addr >= START) && (addr < START + 32'(4 * MPW));
        n    = ok ? ml + lw : 2;
        cur  = sel;
        req_addr = addr;
        rv1 = (sel == 0);
        rv2 = (sel == 1);
        #1;
        chk("ready_before_accept", m_rdy, 32'd1);
        @(posedge clk);
        #1;
        if (keep) req_addr = $urandom;
        else begin
            rv1 = 1'b0;
            rv2 = 1'b0;
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (keep && k == n) req_addr = addr;
            r = k - (ml - 1);
            f = k - ml;
            chk("ready", m_rdy, 32'(k == n));
            chk("hold", m_h, 32'(k < n));
            if (ok) begin
                chk("err", m_e, 32'd0);
                chk("mem_ce_n", m_ce, 32'(!(r >= 0 && r < lw)));
                chk("mem_addr", m_ma, (r >= 0 && r < lw) ? base + 32'(4 * ((crit + r) % lw)) : 32'd0);
                chk("fill_valid", m_fv, 32'(f >= 0 && f < lw));
                chk("fill_data", m_fd, (f >= 0 && f < lw) ? mem_fn(base + 32'(4 * ((crit + f) % lw))) : 32'd0);
                if (f >= 0 && f < lw) chk("fill_idx", m_fi, 32'((crit + f) % lw));
                chk("fill_last", m_fl, 32'(f == lw - 1));
            end else begin
                chk("err", m_e, 32'(k == 1));
                chk("mem_ce_n", m_ce, 32'd1);
                chk("fill_valid", m_fv, 32'd0);
                chk("fill_data", m_fd, 32'd0);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        rv1      = 1'b0;
        rv2      = 1'b0;
        req_addr = 32'd0;
        cur      = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", m_rdy, 32'd0);
        chk("rst_ce", m_ce, 32'd1);
        chk("rst_addr", m_ma, 32'd0);
        chk("rst_fv", m_fv, 32'd0);
        chk("rst_fd", m_fd, 32'd0);
        chk("rst_hold", m_h, 32'd0);
        chk("rst_err", m_e, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", m_rdy, 32'd1);

        run_txn(0, 32'h00400008, 1'b0);
        run_txn(0, 32'h00400008, 1'b1);
        run_txn(0, 32'h0040001C, 1'b1);
        run_txn(0, 32'h003FFFFC, 1'b0);
        run_txn(0, 32'h00408000, 1'b0);
        run_txn(0, 32'h00400000, 1'b0);
        run_txn(0, 32'h00407FFC, 1'b0);
        run_txn(0, 32'h00400005, 1'b0);
        run_txn(1, 32'h00400014, 1'b0);
        run_txn(1, 32'h00400FFF, 1'b1);
        run_txn(1, 32'h00408004, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_txn(int'($urandom_range(0, 1)), 32'h003FF000 + 32'($urandom_range(0, 32'h0000A000)),
                    bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of a burst.
        cur      = 0;
        req_addr = 32'h00400008;
        rv1      = 1'b1;
        rv2      = 1'b0;
        @(posedge clk);
        #1 rv1 = 1'b0;
        repeat (17) @(negedge clk);
        chk("mid_burst_fv", m_fv, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_ce", m_ce, 32'd1);
        chk("arst_addr", m_ma, 32'd0);
        chk("arst_fv", m_fv, 32'd0);
        chk("arst_fd", m_fd, 32'd0);
        chk("arst_fi", m_fi, 32'd0);
        chk("arst_fl", m_fl, 32'd0);
        chk("arst_hold", m_h, 32'd0);
        chk("arst_err", m_e, 32'd0);
        chk("arst_ready", m_rdy, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", m_rdy, 32'd1);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk("no_residual_fv", m_fv, 32'd0);
            chk("no_residual_ce", m_ce, 32'd1);
            chk("no_residual_hold", m_h, 32'd0);
        end
        run_txn(0, 32'h0040000C, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
